// File: rtl/vfd_pkg.sv
// Shared VFD definitions: frequency word width, frequency limits and the ramp FSM state encoding.
package vfd_pkg;

  localparam int VFD_FW   = 10;
  localparam int VFD_FMIN = 5;
  localparam int VFD_FMAX = 1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCEL = 2'd1,
    ST_RUN   = 2'd2,
    ST_DECEL = 2'd3
  } vfd_state_e;

endpackage

// File: rtl/ramp_tick_div.sv
// Divides the 1 ms strobe down to one ramp tick every RAMP_MS strobes; clr holds the count at zero.
module ramp_tick_div #(
  parameter int RAMP_MS = 10
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic clr,
  input  logic pluse_ms,
  output logic tick
);

  localparam int CW = (RAMP_MS > 1) ? $clog2(RAMP_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(RAMP_MS - 1);

  logic [CW-1:0] cnt;

  assign tick = pluse_ms && !clr && (cnt == LAST);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (pluse_ms) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vfd_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: ramps freq_out toward the clamped target once per ramp tick,
// gates PWM enable and latches emergency stop until estop and run are both released.
module vfd_ramp_ctrl
  import vfd_pkg::*;
#(
  parameter int FW       = VFD_FW,
  parameter int FMIN     = VFD_FMIN,
  parameter int FMAX     = VFD_FMAX,
  parameter int ACC_STEP = 2,
  parameter int DEC_STEP = 2,
  parameter int RAMP_MS  = 10
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          pluse_ms,
  input  logic          run,
  input  logic          estop,
  input  logic [FW-1:0] freq_target,
  output logic [FW-1:0] freq_out,
  output logic          pwm_en,
  output logic          at_speed,
  output logic          fault,
  output logic [1:0]    state
);

  localparam logic [FW-1:0] FMIN_F = FW'(FMIN);
  localparam logic [FW-1:0] FMAX_F = FW'(FMAX);
  localparam logic [FW-1:0] DEC_F  = FW'(DEC_STEP);
  localparam logic [FW:0]   ACC_W  = (FW+1)'(ACC_STEP);
  localparam logic [FW:0]   DEC_W  = (FW+1)'(DEC_STEP);

  vfd_state_e    cur;
  logic          tick;
  logic [FW-1:0] tgt, floor_f, acc_next, dec_next;
  logic [FW:0]   acc_sum, floor_sum;

  // Sums are one bit wider so the saturating min/max never sees a wrapped value.
  always_comb begin
    tgt = freq_target;
    if (freq_target < FMIN_F) begin
      tgt = FMIN_F;
    end else if (freq_target > FMAX_F) begin
      tgt = FMAX_F;
    end
    acc_sum   = {1'b0, freq_out} + ACC_W;
    acc_next  = (acc_sum >= {1'b0, tgt}) ? tgt : acc_sum[FW-1:0];
    floor_f   = run ? tgt : FMIN_F;
    floor_sum = {1'b0, floor_f} + DEC_W;
    dec_next  = ({1'b0, freq_out} <= floor_sum) ? floor_f : freq_out - DEC_F;
  end

  ramp_tick_div #(.RAMP_MS(RAMP_MS)) u_tick_div (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .clr      (cur == ST_IDLE),
    .pluse_ms (pluse_ms),
    .tick     (tick)
  );

  assign state = cur;

  // Direction changes take the whole cycle; the step in the new direction waits for the next tick.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cur      <= ST_IDLE;
      freq_out <= '0;
      pwm_en   <= 1'b0;
      at_speed <= 1'b0;
      fault    <= 1'b0;
    end else if (estop) begin
      cur      <= ST_IDLE;
      freq_out <= '0;
      pwm_en   <= 1'b0;
      at_speed <= 1'b0;
      fault    <= 1'b1;
    end else if (fault) begin
      if (!run) fault <= 1'b0;
    end else begin
      at_speed <= 1'b0;
      case (cur)
        ST_IDLE: begin
          if (run) begin
            cur      <= ST_ACCEL;
            freq_out <= FMIN_F;
            pwm_en   <= 1'b1;
          end
        end
        ST_ACCEL: begin
          if (!run || freq_out > tgt) begin
            cur <= ST_DECEL;
          end else if (freq_out == tgt) begin
            cur      <= ST_RUN;
            at_speed <= 1'b1;
          end else if (tick) begin
            freq_out <= acc_next;
          end
        end
        ST_RUN: begin
          if (!run || freq_out > tgt) begin
            cur <= ST_DECEL;
          end else if (freq_out < tgt) begin
            cur <= ST_ACCEL;
          end else begin
            at_speed <= 1'b1;
          end
        end
        ST_DECEL: begin
          if (run && freq_out == tgt) begin
            cur      <= ST_RUN;
            at_speed <= 1'b1;
          end else if (run && freq_out < tgt) begin
            cur <= ST_ACCEL;
          end else if (tick) begin
            if (!run && freq_out == FMIN_F) begin
              cur      <= ST_IDLE;
              freq_out <= '0;
              pwm_en   <= 1'b0;
            end else begin
              freq_out <= dec_next;
            end
          end
        end
        default: cur <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vfd_ramp_ctrl.sv
// Bench for vfd_ramp_ctrl: directed ramp scenarios plus random run/estop/target traffic,
// all checked every cycle against a rule-level model of the sequencer.
module tb_vfd_ramp_ctrl;

  localparam int FW      = 10;
  localparam int FMIN    = 5;
  localparam int FMAX    = 1000;
  localparam int ACC     = 2;
  localparam int DEC     = 2;
  localparam int RAMP_MS = 2;

  // clock / reset
  logic clk_sys = 1'b0;
  logic rst = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic          pluse_ms = 1'b0;
  logic          run = 1'b0;
  logic          estop = 1'b0;
  logic [FW-1:0] freq_target = '0;
  logic [FW-1:0] freq_out;
  logic          pwm_en, at_speed, fault;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  // model: mode 0 idle, 1 accelerating, 2 at speed, 3 decelerating
  int m_freq  = 0;
  int m_mode  = 0;
  int m_div   = 0;
  bit m_fault = 1'b0;

  vfd_ramp_ctrl #(
    .FW(FW), .FMIN(FMIN), .FMAX(FMAX), .ACC_STEP(ACC), .DEC_STEP(DEC), .RAMP_MS(RAMP_MS)
  ) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .pluse_ms    (pluse_ms),
    .run         (run),
    .estop       (estop),
    .freq_target (freq_target),
    .freq_out    (freq_out),
    .pwm_en      (pwm_en),
    .at_speed    (at_speed),
    .fault       (fault),
    .state       (state)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name, input int budget);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no event within %0d cycles, freq_out=%0d state=%0d at %0t",
             name, budget, freq_out, state, $time);
  endtask

  function automatic int clampf(input int v);
    return (v < FMIN) ? FMIN : ((v > FMAX) ? FMAX : v);
  endfunction

  task automatic model_reset();
    m_freq  = 0;
    m_mode  = 0;
    m_div   = 0;
    m_fault = 1'b0;
  endtask

  task automatic model_edge();
    int  tgt, nf, nm;
    bit  tick;
    tgt  = clampf(int'(freq_target));
    tick = 1'b0;
    if (m_mode == 0) begin
      m_div = 0;
    end else if (pluse_ms) begin
      if (m_div == RAMP_MS - 1) begin
        tick  = 1'b1;
        m_div = 0;
      end else begin
        m_div++;
      end
    end
    nf = m_freq;
    nm = m_mode;
    if (estop) begin
      nm = 0; nf = 0; m_fault = 1'b1;
    end else if (m_fault) begin
      if (!run) m_fault = 1'b0;
    end else begin
      case (m_mode)
        0: if (run) begin nm = 1; nf = FMIN; end
        1: begin
          if (!run || m_freq > tgt) nm = 3;
          else if (m_freq == tgt) nm = 2;
          else if (tick) nf = (m_freq + ACC > tgt) ? tgt : m_freq + ACC;
        end
        2: begin
          if (!run || m_freq > tgt) nm = 3;
          else if (m_freq < tgt) nm = 1;
        end
        default: begin
          if (run) begin
            if (m_freq == tgt) nm = 2;
            else if (m_freq < tgt) nm = 1;
            else if (tick) nf = (m_freq - DEC < tgt) ? tgt : m_freq - DEC;
          end else if (tick) begin
            if (m_freq == FMIN) begin nm = 0; nf = 0; end
            else nf = (m_freq - DEC < FMIN) ? FMIN : m_freq - DEC;
          end
        end
      endcase
    end
    m_freq = nf;
    m_mode = nm;
  endtask

  initial begin
    forever begin
      @(posedge clk_sys or posedge rst);
      if (rst) model_reset();
      else model_edge();
    end
  end

  // scoreboard: every cycle out of reset, all outputs against the model
  initial begin
    forever begin
      @(negedge clk_sys);
      if (!rst) begin
        check("freq_out", int'(freq_out), m_freq);
        check("pwm_en", int'(pwm_en), (m_freq != 0) ? 1 : 0);
        check("at_speed", int'(at_speed), (m_mode == 2) ? 1 : 0);
        check("fault", int'(fault), int'(m_fault));
        check("state", int'(state), m_mode);
      end
    end
  end

  // 1 ms strobe with a random 1..3 cycle gap
  initial begin
    forever begin
      repeat ($urandom_range(1, 3)) @(posedge clk_sys);
      #1 pluse_ms = 1'b1;
      @(posedge clk_sys);
      #1 pluse_ms = 1'b0;
    end
  end

  // driver tasks
  task automatic set_in(input bit r, input bit e, input int t);
    #1;
    run         = r;
    estop       = e;
    freq_target = t[FW-1:0];
  endtask

  task automatic wait_change(input string name, input int exp);
    logic [FW-1:0] old;
    int n;
    old = freq_out;
    n = 0;
    while (freq_out == old && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 400) timeout_fail(name, 400);
    check(name, int'(freq_out), exp);
    check({name, "_model"}, m_freq, exp);
  endtask

  task automatic wait_freq(input string name, input int exp, input int budget);
    int n;
    n = 0;
    while (int'(freq_out) != exp && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= budget) timeout_fail(name, budget);
    check(name, int'(freq_out), exp);
  endtask

  task automatic wait_state(input string name, input int st, input int budget);
    int n;
    n = 0;
    while (int'(state) != st && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= budget) timeout_fail(name, budget);
    check(name, int'(state), st);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_freq"}, int'(freq_out), 0);
    check({tag, "_pwm"}, int'(pwm_en), 0);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_at_speed"}, int'(at_speed), 0);
  endtask

  initial begin
    int hold, sel;
    repeat (3) @(negedge clk_sys);
    check_zero("reset");
    check("reset_fault", int'(fault), 0);
    #1 rst = 1'b0;

    // start toward 11
    @(negedge clk_sys);
    set_in(1, 0, 11);
    @(negedge clk_sys);
    check("start_freq", int'(freq_out), 5);
    check("start_pwm", int'(pwm_en), 1);
    check("start_state", int'(state), 1);
    check("start_model", m_freq, 5);
    wait_change("acc_7", 7);
    wait_change("acc_9", 9);
    wait_change("acc_11", 11);
    wait_state("run_11", 2, 20);
    check("run_11_at_speed", int'(at_speed), 1);

    // stop from 11
    set_in(0, 0, 11);
    @(negedge clk_sys);
    check("stop_decel", int'(state), 3);
    check("stop_at_speed", int'(at_speed), 0);
    wait_change("dec_9", 9);
    wait_change("dec_7", 7);
    wait_change("dec_5", 5);
    wait_change("dec_off", 0);
    check_zero("stopped");

    // no overshoot: target lowered to 10 while at 9
    set_in(1, 0, 20);
    @(negedge clk_sys);
    check("restart_freq", int'(freq_out), 5);
    wait_change("b_7", 7);
    wait_change("b_9", 9);
    set_in(1, 0, 10);
    wait_change("no_overshoot", 10);
    wait_state("run_10", 2, 20);
    check("run_10_at_speed", int'(at_speed), 1);

    // target below FMIN clamps to 5 and holds
    set_in(1, 0, 2);
    wait_change("low_8", 8);
    wait_change("low_6", 6);
    wait_change("low_5", 5);
    wait_state("run_5", 2, 20);
    repeat (30) @(negedge clk_sys);
    check("hold_5", int'(freq_out), 5);
    check("hold_5_state", int'(state), 2);

    // reversal during accel
    set_in(1, 0, 20);
    wait_change("rev_7", 7);
    wait_change("rev_9", 9);
    set_in(1, 0, 6);
    @(negedge clk_sys);
    check("rev_decel", int'(state), 3);
    check("rev_no_jump", int'(freq_out), 9);
    wait_change("rev_dec_7", 7);
    wait_change("rev_dec_6", 6);
    wait_state("rev_run", 2, 20);
    check("rev_at_speed", int'(at_speed), 1);

    // clamp at FMAX
    set_in(1, 0, 1023);
    wait_freq("clamp_1000", 1000, 6000);
    wait_state("clamp_run", 2, 20);
    repeat (20) @(negedge clk_sys);
    check("clamp_hold", int'(freq_out), 1000);

    // down to 100, then emergency stop
    set_in(1, 0, 100);
    wait_freq("down_100", 100, 6000);
    wait_state("run_100", 2, 20);
    set_in(1, 1, 100);
    @(negedge clk_sys);
    check_zero("estop");
    check("estop_fault", int'(fault), 1);
    set_in(1, 0, 100);
    repeat (10) @(negedge clk_sys);
    check("latched_fault", int'(fault), 1);
    check("latched_freq", int'(freq_out), 0);
    set_in(0, 0, 100);
    @(negedge clk_sys);
    check("fault_clear", int'(fault), 0);
    set_in(1, 0, 100);
    @(negedge clk_sys);
    check("post_fault_start", int'(freq_out), 5);
    check("post_fault_state", int'(state), 1);

    // async reset mid-ramp
    wait_change("pre_rst_7", 7);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    check("async_rst_fault", int'(fault), 0);
    @(negedge clk_sys);
    #1 rst = 1'b0;
    @(negedge clk_sys);
    check("post_rst_start", int'(freq_out), 5);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      sel  = $urandom_range(0, 99);
      hold = $urandom_range(1, 40);
      if (sel < 3) begin
        #2 rst = 1'b1;
        @(negedge clk_sys);
        #1 rst = 1'b0;
      end else begin
        set_in(sel >= 20,
               sel >= 3 && sel < 7,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 40));
      end
      repeat (hold) @(negedge clk_sys);
    end

    repeat (5) @(negedge clk_sys);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
